// File: rtl/wb_commit_if.sv
// MEM/WB -> writeback handshake and latched pipeline fields.
// Upstream drives through master; the commit stage consumes through slave.
interface wb_commit_if #(
  parameter int unsigned DATA_W = 32
);
  logic                  WB_valid;
  logic                  WB_ready;
  logic [4:0]            RegWr_WB;
  logic [DATA_W-1:0]     Memory_WB;
  logic [DATA_W-1:0]     ALU_WB;
  logic [2*DATA_W-1:0]   OUT_ALU64_WB;
  logic [2*DATA_W-1:0]   OUT_data64_WB;
  logic [DATA_W-1:0]     HILO_write_WB;
  logic [DATA_W-1:0]     PC8_WB;
  logic                  RegWrite;
  logic                  MemToReg;
  logic                  MemToReg64;
  logic                  MulDiv_control;
  logic                  HILO_write_control;
  logic                  Jal_control;
  logic                  FPwrite_control;
  logic                  Load_Byte_control;
  logic                  Write32_64;

  modport master (
    output WB_valid, RegWr_WB, Memory_WB, ALU_WB, OUT_ALU64_WB, OUT_data64_WB,
           HILO_write_WB, PC8_WB, RegWrite, MemToReg, MemToReg64, MulDiv_control,
           HILO_write_control, Jal_control, FPwrite_control, Load_Byte_control,
           Write32_64,
    input  WB_ready
  );

  modport slave (
    input  WB_valid, RegWr_WB, Memory_WB, ALU_WB, OUT_ALU64_WB, OUT_data64_WB,
           HILO_write_WB, PC8_WB, RegWrite, MemToReg, MemToReg64, MulDiv_control,
           HILO_write_control, Jal_control, FPwrite_control, Load_Byte_control,
           Write32_64,
    output WB_ready
  );
endinterface

// File: rtl/wb_commit.sv
// Writeback commit stage: turns retiring instructions into registered
// integer/FP/HI-LO writes; 64-bit FP results are split over two cycles.
module wb_commit #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned JAL_REG   = 31,
  parameter bit          LB_SIGNED = 1'b1
) (
  input  logic              Clk,
  input  logic              Rst_n,
  wb_commit_if.slave        wb,
  output logic              Int_we,
  output logic [4:0]        Int_waddr,
  output logic [DATA_W-1:0] Int_wdata,
  output logic              FP_we,
  output logic [4:0]        FP_waddr,
  output logic [DATA_W-1:0] FP_wdata,
  output logic [DATA_W-1:0] HI,
  output logic [DATA_W-1:0] LO,
  output logic              Align_err
);

  typedef enum logic {IDLE, SECOND} state_t;

  state_t              state, nxt_state;
  logic [DATA_W-1:0]   hold_word, nxt_hold_word;
  logic [3:0]          hold_addr, nxt_hold_addr;
  logic                nxt_int_we, nxt_fp_we, nxt_align;
  logic [4:0]          nxt_int_waddr, nxt_fp_waddr;
  logic [DATA_W-1:0]   nxt_int_wdata, nxt_fp_wdata, nxt_hi, nxt_lo;
  logic [DATA_W-1:0]   word_data, byte_data;
  logic [2*DATA_W-1:0] dbl_data;
  logic                accept;

  assign wb.WB_ready = (state == IDLE);
  assign accept      = wb.WB_valid && (state == IDLE);

  assign byte_data = {{(DATA_W-8){LB_SIGNED ? wb.Memory_WB[7] : 1'b0}}, wb.Memory_WB[7:0]};
  assign word_data = wb.MemToReg ? wb.Memory_WB : wb.ALU_WB;
  assign dbl_data  = wb.MemToReg64 ? wb.OUT_data64_WB : wb.OUT_ALU64_WB;

  always_comb begin
    nxt_state     = state;
    nxt_hold_word = hold_word;
    nxt_hold_addr = hold_addr;
    nxt_int_we    = 1'b0;
    nxt_int_waddr = Int_waddr;
    nxt_int_wdata = Int_wdata;
    nxt_fp_we     = 1'b0;
    nxt_fp_waddr  = FP_waddr;
    nxt_fp_wdata  = FP_wdata;
    nxt_align     = 1'b0;
    nxt_hi        = HI;
    nxt_lo        = LO;

    unique case (state)
      IDLE: begin
        if (accept) begin
          if (wb.Jal_control) begin
            nxt_int_we    = 1'b1;
            nxt_int_waddr = 5'(JAL_REG);
            nxt_int_wdata = wb.PC8_WB;
          end else if (wb.RegWrite && !wb.FPwrite_control) begin
            nxt_int_we    = (wb.RegWr_WB != 5'd0);
            nxt_int_waddr = wb.RegWr_WB;
            nxt_int_wdata = (wb.MemToReg && wb.Load_Byte_control) ? byte_data : word_data;
          end else if (wb.RegWrite && !wb.Write32_64) begin
            nxt_fp_we    = 1'b1;
            nxt_fp_waddr = wb.RegWr_WB;
            nxt_fp_wdata = word_data;
          end else if (wb.RegWrite) begin
            // Low half now; odd destination is forced even and flagged.
            nxt_fp_we     = 1'b1;
            nxt_fp_waddr  = {wb.RegWr_WB[4:1], 1'b0};
            nxt_fp_wdata  = dbl_data[DATA_W-1:0];
            nxt_align     = wb.RegWr_WB[0];
            nxt_hold_word = dbl_data[2*DATA_W-1:DATA_W];
            nxt_hold_addr = wb.RegWr_WB[4:1];
            nxt_state     = SECOND;
          end

          if (wb.MulDiv_control) begin
            nxt_hi = wb.OUT_ALU64_WB[2*DATA_W-1:DATA_W];
            nxt_lo = wb.OUT_ALU64_WB[DATA_W-1:0];
          end else if (wb.HILO_write_control) begin
            if (wb.RegWr_WB[0]) nxt_hi = wb.HILO_write_WB;
            else                nxt_lo = wb.HILO_write_WB;
          end
        end
      end
      SECOND: begin
        nxt_fp_we    = 1'b1;
        nxt_fp_waddr = {hold_addr, 1'b1};
        nxt_fp_wdata = hold_word;
        nxt_state    = IDLE;
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= IDLE;
      hold_word <= '0;
      hold_addr <= '0;
      Int_we    <= 1'b0;
      Int_waddr <= '0;
      Int_wdata <= '0;
      FP_we     <= 1'b0;
      FP_waddr  <= '0;
      FP_wdata  <= '0;
      HI        <= '0;
      LO        <= '0;
      Align_err <= 1'b0;
    end else begin
      state     <= nxt_state;
      hold_word <= nxt_hold_word;
      hold_addr <= nxt_hold_addr;
      Int_we    <= nxt_int_we;
      Int_waddr <= nxt_int_waddr;
      Int_wdata <= nxt_int_wdata;
      FP_we     <= nxt_fp_we;
      FP_waddr  <= nxt_fp_waddr;
      FP_wdata  <= nxt_fp_wdata;
      HI        <= nxt_hi;
      LO        <= nxt_lo;
      Align_err <= nxt_align;
    end
  end

endmodule

// File: doc/wb_commit.md
Name: wb_commit

Overview:
- Writeback commit stage. Sits downstream of the MEM/WB pipeline register and consumes its latched fields and decoded control bits.
- Turns each retiring instruction into register-file write-port transactions for the integer file, the FP file and HI/LO.
- A 64-bit (double) result is sequenced as two 32-bit FP writes. `WB_ready` is deasserted for one cycle so the upstream register holds.

Parameters:
- DATA_W, 32, width of one register-file write word.
- JAL_REG, 31, integer register written by Jal_control.
- LB_SIGNED, 1, 1 = sign-extend load-byte data, 0 = zero-extend.

Ports:
- Clk in 1: system clock; all state updates on posedge.
- Rst_n in 1: asynchronous active-low reset.
- WB_valid in 1: MEM/WB fields valid this cycle.
- WB_ready out 1: block can accept; equals (state==IDLE).
- RegWr_WB in 5: destination register.
- Memory_WB in 32: load data.
- ALU_WB in 32: ALU/address result.
- OUT_ALU64_WB in 64: 64-bit ALU / mul-div result {hi,lo}.
- OUT_data64_WB in 64: 64-bit load data {hi,lo}.
- HILO_write_WB in 32: mthi/mtlo source.
- PC8_WB in 32: return address for jal.
- RegWrite, MemToReg, MemToReg64, MulDiv_control, HILO_write_control, Jal_control, FPwrite_control, Load_Byte_control, Write32_64 in 1 each: writeback controls.
- Int_we out 1; Int_waddr out 5; Int_wdata out 32: integer write port.
- FP_we out 1; FP_waddr out 5; FP_wdata out 32: FP write port.
- HI out 32; LO out 32: HI/LO architectural registers.
- Align_err out 1: one-cycle pulse on odd destination for 64-bit write.

Behaviour:
- Reset (Rst_n=0, async): state=IDLE; all outputs 0 (Int_*, FP_*, HI, LO, Align_err); high-word holding register cleared. Reset during SECOND aborts; the high half is never written.
- All write-port outputs are registered. Accept on posedge with WB_valid & WB_ready; the port is valid the following cycle (latency 1). We signals are single-cycle pulses.
- Transaction routing, evaluated at accept:
  - Jal_control=1: Int_waddr=JAL_REG, Int_wdata=PC8_WB. Overrides the RegWrite path.
  - RegWrite=1 & FPwrite_control=0: integer write. Data is MemToReg ? (Load_Byte_control ? ext(Memory_WB[7:0]) : Memory_WB) : ALU_WB.
  - RegWr_WB=0 on the integer path: Int_we stays 0 (r0 is never written).
  - RegWrite=1 & FPwrite_control=1 & Write32_64=0: single FP write, same data mux (no byte extension).
  - RegWrite=1 & FPwrite_control=1 & Write32_64=1: double write. D = MemToReg64 ? OUT_data64_WB : OUT_ALU64_WB.
    - Cycle 1: FP_waddr={RegWr_WB[4:1],0}, FP_wdata=D[31:0].
    - Store D[63:32]; go to SECOND.
    - Cycle 2: FP_waddr={RegWr_WB[4:1],1}, FP_wdata=D[63:32]; return to IDLE.
    - RegWr_WB[0]=1: bit forced to 0 and Align_err pulses with the first write.
  - MulDiv_control=1: HI<=OUT_ALU64_WB[63:32], LO<=OUT_ALU64_WB[31:0].
  - Else HILO_write_control=1: RegWr_WB[0]=1 writes HI, otherwise writes LO, with HILO_write_WB.
  - HI/LO update in the accept cycle, independent of the register-port writes. MulDiv has priority over HILO_write.
- FSM states: IDLE, SECOND.
  - IDLE → SECOND only on an accepted double write.
  - SECOND → IDLE unconditionally next cycle.
  - WB_valid in SECOND is not consumed; upstream holds its fields.
- An integer write and an FP write never occur for the same instruction. Both ports may be active in the same cycle only via an integer write following the second FP half (not possible while in SECOND).

Test Plan:
- Reset mid-double: accept a double write, assert Rst_n=0 during SECOND → FP_we=0, HI=LO=0, state IDLE, WB_ready=1.
- Integer load byte: Memory_WB=0x000000F3, MemToReg=1, Load_Byte_control=1, RegWr=5 → next cycle Int_we=1, Int_waddr=5, Int_wdata=0xFFFFFFF3.
- r0 suppression: RegWrite=1, RegWr=0, ALU_WB=0x1234 → Int_we stays 0. Jal with PC8_WB=0x40 → Int_waddr=31, Int_wdata=0x40.
- FP double: OUT_data64=0x11112222_33334444, MemToReg64=1, RegWr=6, WB_valid held 2 cycles.
  - Cycle+1: FP_waddr=6, FP_wdata=0x33334444, WB_ready=0.
  - Cycle+2: FP_waddr=7, FP_wdata=0x11112222.
  - Second valid accepted only after WB_ready returns to 1.
- Odd double: RegWr=9, Write32_64=1 → writes go to regs 8 then 9; Align_err=1 for exactly one cycle.
- HI/LO:
  - MulDiv_control=1, OUT_ALU64=0xAAAA0000_0000BBBB → HI=0xAAAA0000, LO=0x0000BBBB.
  - Then HILO_write_control=1, RegWr[0]=0, HILO_write=0x5 → LO=5, HI unchanged.
  - Both controls asserted → MulDiv result wins.
